// File: rtl/life_step.sv
// ---------------------------------------------------------------------------
// life_step
//
// Game-of-life generation engine. A rising edge on the divided-clock level
// i_tick starts a new generation. The engine computes one row per i_clk
// cycle into a shadow grid (nxt), then copies the whole grid into the
// displayed grid (cur) in a single COMMIT cycle.
//
// Configuration macro:
//   LIFE_TORUS_EN  defined   -> grid edges wrap (toroidal neighbourhood)
//                  undefined -> cells outside the grid read as dead
//
// Ports:
//   i_clk        system clock
//   i_rst        asynchronous reset, active-high
//   i_tick       divided clock level, synchronous to i_clk
//   i_run        1 = accept ticks, 0 = ignore ticks
//   i_load       row write strobe for cur (honoured only in IDLE)
//   i_load_addr  row written on i_load
//   i_load_data  row data, bit x = cell x, 1 = alive
//   i_rd_addr    display read row
//   o_rd_data    combinational read of cur, 0 for out-of-range rows
//   o_busy       high in CALC and COMMIT
//   o_done       one-cycle pulse when a new generation becomes visible
//   o_gen        number of completed generations (wraps)
//   o_overrun    sticky: a tick edge arrived while busy
// ---------------------------------------------------------------------------
module life_step #(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 8,
    parameter int ADDR_W = 3,
    parameter int GEN_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_tick,
    input  logic              i_run,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_load_addr,
    input  logic [WIDTH-1:0]  i_load_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [WIDTH-1:0]  o_rd_data,
    output logic              o_busy,
    output logic              o_done,
    output logic [GEN_W-1:0]  o_gen,
    output logic              o_overrun
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // One extra bit so HEIGHT == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0]   HEIGHT_W = (ADDR_W+1)'(HEIGHT);
    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(HEIGHT - 1);

    state_t             r_state;
    state_t             w_stateNext;
    logic               r_tickQ;
    logic               w_tickRise;
    logic [ADDR_W-1:0]  r_row;
    logic [WIDTH-1:0]   r_cur [HEIGHT];
    logic [WIDTH-1:0]   r_nxt [HEIGHT];
    logic [GEN_W-1:0]   r_gen;
    logic               r_done;
    logic               r_overrun;
    logic               w_loadOk;
    logic               w_startCalc;

    logic [WIDTH-1:0]   w_rowAbove;
    logic [WIDTH-1:0]   w_rowMid;
    logic [WIDTH-1:0]   w_rowBelow;
    logic [WIDTH+1:0]   w_extAbove;
    logic [WIDTH+1:0]   w_extMid;
    logic [WIDTH+1:0]   w_extBelow;
    logic [3:0]         w_count [WIDTH];
    logic [WIDTH-1:0]   w_rowNext;

    assign w_tickRise  = i_tick & ~r_tickQ;
    assign w_loadOk    = (r_state == IDLE) && i_load &&
                         ({1'b0, i_load_addr} < HEIGHT_W);
    // A valid load in IDLE takes priority and silently swallows a coincident tick.
    assign w_startCalc = (r_state == IDLE) && !w_loadOk && w_tickRise && i_run;

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state logic: IDLE -> CALC for HEIGHT rows -> COMMIT -> IDLE.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE:    if (w_startCalc) w_stateNext = CALC;
            CALC:    if (r_row == LAST_ROW) w_stateNext = COMMIT;
            COMMIT:  w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    // Output decode of the state machine.
    always_comb begin
        o_busy = (r_state == CALC) || (r_state == COMMIT);
    end

    // Select the three source rows around the row being computed. Off-grid
    // rows and columns are either dead or wrapped, depending on the build.
    always_comb begin
        w_rowMid = r_cur[r_row];
`ifdef LIFE_TORUS_EN
        w_rowAbove = (r_row == '0)       ? r_cur[LAST_ROW] : r_cur[r_row - 1'b1];
        w_rowBelow = (r_row == LAST_ROW) ? r_cur[0]        : r_cur[r_row + 1'b1];
        w_extAbove = {w_rowAbove[0], w_rowAbove, w_rowAbove[WIDTH-1]};
        w_extMid   = {w_rowMid[0],   w_rowMid,   w_rowMid[WIDTH-1]};
        w_extBelow = {w_rowBelow[0], w_rowBelow, w_rowBelow[WIDTH-1]};
`else
        w_rowAbove = (r_row == '0)       ? '0 : r_cur[r_row - 1'b1];
        w_rowBelow = (r_row == LAST_ROW) ? '0 : r_cur[r_row + 1'b1];
        w_extAbove = {1'b0, w_rowAbove, 1'b0};
        w_extMid   = {1'b0, w_rowMid,   1'b0};
        w_extBelow = {1'b0, w_rowBelow, 1'b0};
`endif
    end

    // Neighbour count and life rule for every cell of the current row.
    // In the extended rows, index x+1 is column x, so columns x-1..x+1
    // sit at indices x..x+2.
    always_comb begin
        w_rowNext = '0;
        for (int x = 0; x < WIDTH; x++) begin
            w_count[x] = {3'b000, w_extAbove[x]} + {3'b000, w_extAbove[x+1]} +
                         {3'b000, w_extAbove[x+2]} +
                         {3'b000, w_extMid[x]}   + {3'b000, w_extMid[x+2]} +
                         {3'b000, w_extBelow[x]} + {3'b000, w_extBelow[x+1]} +
                         {3'b000, w_extBelow[x+2]};
            w_rowNext[x] = (w_count[x] == 4'd3) |
                           (w_rowMid[x] & (w_count[x] == 4'd2));
        end
    end

    // Datapath: tick edge detect, grid storage, counters and status flags.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tickQ   <= 1'b0;
            r_row     <= '0;
            r_gen     <= '0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
            for (int i = 0; i < HEIGHT; i++) begin
                r_cur[i] <= '0;
                r_nxt[i] <= '0;
            end
        end else begin
            r_tickQ <= i_tick;
            r_done  <= (r_state == COMMIT);
            if (w_tickRise && o_busy) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (w_loadOk) begin
                        r_cur[i_load_addr] <= i_load_data;
                    end else if (w_startCalc) begin
                        r_row <= '0;
                    end
                end
                CALC: begin
                    r_nxt[r_row] <= w_rowNext;
                    r_row        <= r_row + 1'b1;
                end
                COMMIT: begin
                    for (int i = 0; i < HEIGHT; i++) begin
                        r_cur[i] <= r_nxt[i];
                    end
                    r_gen <= r_gen + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Display read port, always showing the committed generation.
    always_comb begin
        o_rd_data = '0;
        if ({1'b0, i_rd_addr} < HEIGHT_W) begin
            o_rd_data = r_cur[i_rd_addr];
        end
    end

    assign o_gen     = r_gen;
    assign o_done    = r_done;
    assign o_overrun = r_overrun;

endmodule

// File: tb/tb_life_step.sv
// ---------------------------------------------------------------------------
// tb_life_step
//
// Directed bench for life_step (8x8 grid). Drives inputs just after the
// falling edge and samples outputs there too, well away from the rising edge.
// Edge-wrap expectations follow LIFE_TORUS_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_life_step;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic        run = 1'b1;
    logic        load = 1'b0;
    logic [2:0]  loadAddr = '0;
    logic [7:0]  loadData = '0;
    logic [2:0]  rdAddr = '0;
    logic [7:0]  rdData;
    logic        busy;
    logic        done;
    logic [15:0] gen;
    logic        overrun;

    int nChecks = 0;
    int nPass   = 0;
    int nFail   = 0;
    int pulses;
    logic busySeen;

    life_step #(
        .WIDTH (8),
        .HEIGHT(8),
        .ADDR_W(3),
        .GEN_W (16)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_tick     (tick),
        .i_run      (run),
        .i_load     (load),
        .i_load_addr(loadAddr),
        .i_load_data(loadData),
        .i_rd_addr  (rdAddr),
        .o_rd_data  (rdData),
        .o_busy     (busy),
        .o_done     (done),
        .o_gen      (gen),
        .o_overrun  (overrun)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // One comparison: counts it and reports any difference.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nChecks++;
        assert (observed === expected) begin
            nPass++;
        end else begin
            nFail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reads one grid row through the display port and compares it.
    task automatic checkRow(input string tag, input logic [2:0] addr,
                            input logic [7:0] expected);
        rdAddr = addr;
        #1;
        checkOutput(tag, {24'd0, rdData}, {24'd0, expected});
    endtask

    // Writes one row through the load port (one cycle strobe).
    task automatic applyStimulus(input logic [2:0] addr, input logic [7:0] data);
        load     = 1'b1;
        loadAddr = addr;
        loadData = data;
        @(negedge clk);
        load = 1'b0;
    endtask

    // One-cycle high level on i_tick; returns right after the rising edge that sampled it.
    task automatic pulseTick();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    // Tick and then watch a bounded window, counting o_done pulses.
    task automatic runGeneration(output int nDone);
        nDone = 0;
        pulseTick();
        repeat (12) begin
            @(negedge clk);
            nDone += int'(done);
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        // ---------------- reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_gen", {16'd0, gen}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_done", {31'd0, done}, 32'd0);
        checkOutput("reset_overrun", {31'd0, overrun}, 32'd0);
        checkRow("reset_row0", 3'd0, 8'h00);

        // ---------------- blinker with exact latency
        applyStimulus(3'd3, 8'h08);
        applyStimulus(3'd4, 8'h08);
        applyStimulus(3'd5, 8'h08);
        pulseTick();
        checkOutput("calc_busy", {31'd0, busy}, 32'd1);
        repeat (8) @(negedge clk);
        checkOutput("commit_busy", {31'd0, busy}, 32'd1);
        checkOutput("commit_done_early", {31'd0, done}, 32'd0);
        checkRow("old_gen_visible", 3'd4, 8'h08);
        @(negedge clk);
        checkOutput("blinker_done", {31'd0, done}, 32'd1);
        checkOutput("blinker_gen1", {16'd0, gen}, 32'd1);
        checkOutput("blinker_idle", {31'd0, busy}, 32'd0);
        checkRow("blinker_row3", 3'd3, 8'h00);
        checkRow("blinker_row4", 3'd4, 8'h1C);
        checkRow("blinker_row5", 3'd5, 8'h00);
        @(negedge clk);
        checkOutput("done_one_cycle", {31'd0, done}, 32'd0);
        runGeneration(pulses);
        checkOutput("blinker2_pulses", pulses, 32'd1);
        checkOutput("blinker2_gen", {16'd0, gen}, 32'd2);
        checkRow("blinker2_row3", 3'd3, 8'h08);
        checkRow("blinker2_row4", 3'd4, 8'h08);
        checkRow("blinker2_row5", 3'd5, 8'h08);

        // ---------------- block still life
        doReset();
        applyStimulus(3'd2, 8'h18);
        applyStimulus(3'd3, 8'h18);
        repeat (3) runGeneration(pulses);
        checkOutput("block_gen", {16'd0, gen}, 32'd3);
        checkOutput("block_overrun", {31'd0, overrun}, 32'd0);
        checkRow("block_row1", 3'd1, 8'h00);
        checkRow("block_row2", 3'd2, 8'h18);
        checkRow("block_row3", 3'd3, 8'h18);
        checkRow("block_row4", 3'd4, 8'h00);

        // ---------------- edge behaviour at column 0 / row 0
        doReset();
        applyStimulus(3'd0, 8'h01);
        applyStimulus(3'd1, 8'h01);
        applyStimulus(3'd2, 8'h01);
        runGeneration(pulses);
`ifdef LIFE_TORUS_EN
        checkRow("edge_row1", 3'd1, 8'h83);
`else
        checkRow("edge_row1", 3'd1, 8'h03);
`endif
        checkRow("edge_row0", 3'd0, 8'h00);
        checkRow("edge_row2", 3'd2, 8'h00);
        checkRow("edge_row7", 3'd7, 8'h00);

        // ---------------- busy protection
        doReset();
        applyStimulus(3'd3, 8'h08);
        applyStimulus(3'd4, 8'h08);
        applyStimulus(3'd5, 8'h08);
        pulseTick();
        load     = 1'b1;
        loadAddr = 3'd0;
        loadData = 8'hFF;
        @(negedge clk);
        load = 1'b0;
        checkOutput("busy_no_overrun_yet", {31'd0, overrun}, 32'd0);
        pulseTick();
        checkOutput("busy_overrun_set", {31'd0, overrun}, 32'd1);
        repeat (12) @(negedge clk);
        checkRow("busy_row0_untouched", 3'd0, 8'h00);
        checkRow("busy_row4", 3'd4, 8'h1C);
        checkOutput("busy_gen_once", {16'd0, gen}, 32'd1);
        runGeneration(pulses);
        checkOutput("overrun_sticky", {31'd0, overrun}, 32'd1);
        checkOutput("busy_gen_after", {16'd0, gen}, 32'd2);

        // ---------------- run gating
        doReset();
        run      = 1'b0;
        busySeen = 1'b0;
        repeat (5) begin
            pulseTick();
            busySeen |= busy;
            repeat (3) begin
                @(negedge clk);
                busySeen |= busy;
            end
        end
        checkOutput("gated_gen", {16'd0, gen}, 32'd0);
        checkOutput("gated_busy_seen", {31'd0, busySeen}, 32'd0);
        checkOutput("gated_overrun", {31'd0, overrun}, 32'd0);
        run = 1'b1;

        // ---------------- load beats a coincident tick in IDLE
        load     = 1'b1;
        loadAddr = 3'd2;
        loadData = 8'h5A;
        tick     = 1'b1;
        @(negedge clk);
        load = 1'b0;
        tick = 1'b0;
        checkOutput("prio_busy", {31'd0, busy}, 32'd0);
        repeat (12) @(negedge clk);
        checkOutput("prio_gen", {16'd0, gen}, 32'd0);
        checkOutput("prio_overrun", {31'd0, overrun}, 32'd0);
        checkRow("prio_row2", 3'd2, 8'h5A);

        // ---------------- reset in the middle of CALC
        doReset();
        applyStimulus(3'd3, 8'h08);
        applyStimulus(3'd4, 8'h08);
        applyStimulus(3'd5, 8'h08);
        runGeneration(pulses);
        checkOutput("pre_reset_gen", {16'd0, gen}, 32'd1);
        pulseTick();
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midreset_busy", {31'd0, busy}, 32'd0);
        checkOutput("midreset_gen", {16'd0, gen}, 32'd0);
        checkOutput("midreset_done", {31'd0, done}, 32'd0);
        for (int r = 0; r < 8; r++) begin
            checkRow($sformatf("midreset_row%0d", r), 3'(r), 8'h00);
        end
        @(negedge clk);
        rst    = 1'b0;
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            pulses += int'(done);
        end
        checkOutput("midreset_no_done", pulses, 32'd0);
        checkOutput("midreset_gen_after", {16'd0, gen}, 32'd0);
        checkRow("midreset_row4_after", 3'd4, 8'h00);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/life_step.md
Name: life_step

Overview:
- Game-of-life generation engine.
- Consumes the slow divided clock produced by the clock divider as a level input `i_tick`, sampled in the `i_clk` domain.
- Each rising edge of `i_tick` advances a WIDTH x HEIGHT cell grid by one generation, computed row-serially.
- Provides a row load port for seeding the grid and a row read port for the display stage downstream.

Parameters:
- WIDTH, 8, cells per row; also the bit width of the load and read data.
- HEIGHT, 8, number of rows; must be at least 3.
- ADDR_W, 3, row address width; must satisfy 2^ADDR_W >= HEIGHT.
- GEN_W, 16, width of the generation counter.

Ports:
- i_clk  input  1  system clock.
- i_rst  input  1  asynchronous reset, active-high.
- i_tick  input  1  divided clock level from the divider, synchronous to `i_clk`.
- i_run  input  1  1 = accept ticks; 0 = ticks ignored.
- i_load  input  1  write strobe for the cur grid.
- i_load_addr  input  ADDR_W  row written on `i_load`.
- i_load_data  input  WIDTH  row data; bit x = cell x, 1 = alive.
- i_rd_addr  input  ADDR_W  display read row.
- o_rd_data  output  WIDTH  combinational read of the cur grid at `i_rd_addr`; 0 if the address >= HEIGHT.
- o_busy  output  1  high while state is CALC or COMMIT.
- o_done  output  1  one-cycle pulse once the new generation is visible.
- o_gen  output  GEN_W  count of generations completed.
- o_overrun  output  1  sticky flag: a tick was lost while busy.

Behaviour:
- Reset, asynchronous, asserted by `i_rst` high:
  - cur and nxt grids all 0.
  - `tick_q` = 0, state = IDLE, row counter = 0.
  - `o_done` = 0, `o_gen` = 0, `o_overrun` = 0.
  - Reset during CALC or COMMIT aborts the computation; nothing is committed.
- Edge detect:
  - `tick_q` <= `i_tick` every cycle.
  - `tick_rise` = `i_tick` & ~`tick_q`, combinational.
- FSM states: IDLE, CALC, COMMIT.
- IDLE:
  - If `i_load` is high and `i_load_addr` < HEIGHT, cur[`i_load_addr`] <= `i_load_data`. Out-of-range addresses are ignored.
  - Else if `tick_rise` is high and `i_run` is high: row <= 0, go to CALC.
  - Load wins over a simultaneous tick; that tick is dropped silently and does not set `o_overrun`.
- CALC:
  - One row r per cycle, r = 0..HEIGHT-1.
  - For each cell (x, r), count the 8 neighbours in cur rows r-1, r, r+1 and columns x-1, x, x+1. The count is 4 bits, range 0..8.
  - nxt[r][x] = (count == 3) | (cur[r][x] & count == 2).
  - After row HEIGHT-1, go to COMMIT.
  - CALC lasts exactly HEIGHT cycles.
- COMMIT, one cycle:
  - cur <= nxt.
  - `o_gen` <= `o_gen` + 1, wrapping modulo 2^GEN_W.
  - `o_done` <= 1.
  - Go to IDLE.
- Latency:
  - Let N be the first `i_clk` edge at which `i_tick` is sampled high after being low.
  - CALC occupies cycles N+1 .. N+HEIGHT.
  - COMMIT is at N+HEIGHT+1.
  - New cur, incremented `o_gen` and `o_done` = 1 are visible after edge N+HEIGHT+1, for one cycle.
- Busy rules:
  - `i_load` is ignored while `o_busy` is high.
  - A `tick_rise` while busy (regardless of `i_run`) sets `o_overrun`. It is cleared only by reset.
- `o_rd_data` reflects cur at all times, so the display sees the old generation until COMMIT.

Optional Feature:
- Macro: LIFE_TORUS_EN.
- Defined: the grid is toroidal.
  - Row -1 maps to HEIGHT-1 and row HEIGHT maps to 0.
  - Column -1 maps to WIDTH-1 and column WIDTH maps to 0.
- Undefined: cells outside the grid read as dead (0). There is no wrap.

Test Plan:
- Blinker: load rows 3..5 = 8'h08 (column 3). Pulse `i_tick` with `i_run` = 1.
  - After HEIGHT+2 cycles: row 4 = 8'h1C, rows 3 and 5 = 0, `o_gen` = 1, one `o_done` pulse.
  - A second tick restores the vertical blinker, `o_gen` = 2.
- Block still life: rows 2 and 3 = 8'h18. Run 3 ticks.
  - Grid unchanged, `o_gen` = 3, `o_overrun` = 0.
- Edge wrap: vertical blinker in column 0, rows 0..2 = 8'h01.
  - With LIFE_TORUS_EN: row 1 = 8'h83.
  - Without it: row 1 = 8'h03 and row 7 = 0.
- Busy protection: during CALC, assert `i_load` with row 0 = 8'hFF, then raise a second `i_tick` edge.
  - Row 0 is not written; `o_overrun` = 1 and stays 1 until reset.
  - `o_gen` increments only once.
- Gating and priority:
  - `i_run` = 0 with 5 ticks: `o_gen` = 0, `o_busy` never high.
  - In IDLE, `i_load` coincident with `tick_rise`: the load is applied, no CALC occurs, `o_overrun` = 0.
- Reset mid-CALC: assert `i_rst` at CALC row 4.
  - Immediately: `o_busy` = 0, `o_gen` = 0, all rows read 0, no `o_done` pulse.
